ifmap_spad: RTL and testbench
=============================

Name: ifmap_spad

Overview:
- Per-PE ifmap scratchpad; sits directly downstream of the ifmap bank loader and receives one diagonal word per cycle.
- Holds the current convolution window of ic*filter_width ifmap values. The window is laid out with ic varying fastest, then filter column.
- Streams the window out sequentially to the PE MAC and can replay it as often as needed.
- On a stride, discards the oldest filter column (ic entries) so only ic new values must be loaded per output column.

Parameters:
- DATA_W, 16, width of one ifmap value.
- DEPTH, 12, number of spad entries.
- AW, 4, pointer/occupancy width; must satisfy 2^AW > DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse: clear contents, latch cfg_ic and cfg_fw.
- cfg_ic  in  5  channels per PE (ic).
- cfg_fw  in  5  filter width.
- wr_en  in  1  write strobe from the diagonal wire.
- wr_data  in  DATA_W  ifmap value.
- rd_en  in  1  MAC requests the next window element.
- slide  in  1  pulse: advance the window by one stride.
- rd_data  out  DATA_W  element read.
- rd_valid  out  1  rd_data valid.
- win_done  out  1  pulse alongside the last element of the window.
- win_ready  out  1  a full window is resident.
- full  out  1  occupancy == DEPTH.
- occ  out  AW  current occupancy.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, base_ptr, rd_off, occ = 0.
  - rd_data = 0; rd_valid, win_done, err = 0; latched ic and fw = 0.
  - Storage contents are don't-care.
  - Reset mid-operation aborts everything immediately.
- Window size W = ic*fw, computed from the latched values and 10 bits wide.
  - If W == 0 or W > DEPTH, the configuration is invalid: err is set, win_ready is held 0, and reads and slides are ignored.
  - Writes are still accepted while the configuration is invalid.
- start (synchronous): pointers and occ cleared, cfg latched, err cleared.
  - start overrides every other input in the same cycle.
- win_ready = (occ >= W) and configuration valid; combinational from registers.
- full = (occ == DEPTH).
- Write: when wr_en=1 and not full:
  - mem[wr_ptr] <= wr_data.
  - wr_ptr advances mod DEPTH.
  - occ increments.
- Write while full: data dropped, err set, pointers unchanged.
- Read: when rd_en=1, win_ready=1 and slide=0:
  - rd_data <= mem[(base_ptr+rd_off) mod DEPTH], with rd_valid=1 on the next cycle (latency 1).
  - If rd_off == W-1: rd_off <= 0 and win_done=1 together with that rd_valid; otherwise rd_off increments.
  - Reading never changes occ; the window can be replayed indefinitely.
- rd_en with win_ready=0: ignored, rd_valid=0, no error.
- rd_valid and win_done are single-cycle; both are 0 when no read was issued in the previous cycle.
- Slide: when slide=1 and occ >= ic:
  - base_ptr advances by ic mod DEPTH.
  - occ decreases by ic.
  - rd_off <= 0.
- Slide with occ < ic: ignored, err set.
- slide has priority over rd_en in the same cycle; the read is dropped.
- Simultaneous wr_en and slide:
  - Both apply; net occ = occ + 1 - ic.
  - full is evaluated before the slide, so a write while full is still dropped.
- A slide while a window is partially read restarts the next read at offset 0 of the new window.
- All pointer arithmetic wraps modulo DEPTH (DEPTH need not be a power of 2: compare and subtract, never mask).

Test Plan:
- Fill and read:
  - Stimulus: start with ic=2, fw=3; write 1..6 on consecutive cycles.
  - Response: win_ready rises the cycle after the 6th write. Six rd_en cycles return rd_data 1,2,3,4,5,6; win_done asserts with value 6; occ stays 6.
- Replay:
  - Stimulus: issue 12 further rd_en cycles without sliding.
  - Response: sequence 1..6 repeats twice, with win_done on each 6.
- Slide:
  - Stimulus: slide, then write 7,8.
  - Response: occ goes 6→4→6. Next window reads 3,4,5,6,7,8.
- Wrap and full:
  - Stimulus: ic=2, fw=3; write 1..12.
  - Response: full=1. Writing 13 sets err and occ stays 12.
  - Stimulus: slide ×3, then write 13..18.
  - Response: window reads 7..12; next slide then reads 9..14. Pointers wrap correctly.
- Config error:
  - Stimulus: start with ic=4, fw=4.
  - Response: err=1 and win_ready=0 even after 12 writes; rd_en yields rd_valid=0.
- Reset and priority:
  - Stimulus: assert rst mid-read.
  - Response: rd_valid and occ are 0 in the same cycle (async).
  - Stimulus: slide and rd_en in the same cycle.
  - Response: no rd_valid next cycle; the read restarts at offset 0.

Source files
------------

// File: rtl/ifmap_spad_if.sv
// ifmap_spad_if: bundles the scratchpad's control, write and read signals.
//   master : the side feeding the spad (loader / MAC / controller).
//   slave  : the scratchpad itself.
// Signals:
//   start, cfg_ic, cfg_fw      window (re)configuration
//   wr_en, wr_data             diagonal write stream
//   rd_en, slide               window read request / stride advance
//   rd_data, rd_valid, win_done read response
//   win_ready, full, occ, err  status
interface ifmap_spad_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 4
);
    logic              start;
    logic [4:0]        cfg_ic;
    logic [4:0]        cfg_fw;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              slide;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              win_done;
    logic              win_ready;
    logic              full;
    logic [AW-1:0]     occ;
    logic              err;

    modport master (
        output start, cfg_ic, cfg_fw, wr_en, wr_data, rd_en, slide,
        input  rd_data, rd_valid, win_done, win_ready, full, occ, err
    );

    modport slave (
        input  start, cfg_ic, cfg_fw, wr_en, wr_data, rd_en, slide,
        output rd_data, rd_valid, win_done, win_ready, full, occ, err
    );
endinterface

// File: rtl/ifmap_spad.sv
// ifmap_spad: per-PE ifmap scratchpad holding one convolution window of
// ic*fw values (ic fastest, then filter column). The window is streamed
// out one element per rd_en and can be replayed indefinitely; slide drops
// the oldest filter column (ic entries) so only ic new values are needed
// per output column. Storage is a circular buffer of DEPTH entries.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - ifmap_spad_if.slave (config, write, read, status)
module ifmap_spad #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 12,
    parameter int AW     = 4
) (
    input  logic         clk,
    input  logic         rst,
    ifmap_spad_if.slave  bus
);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [9:0]    DEPTH_W = 10'(DEPTH);

    // Circular add: DEPTH need not be a power of two, so compare and
    // subtract instead of masking. inc never exceeds DEPTH, so one
    // subtraction is enough.
    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] ptr,
                                              input logic [AW-1:0] inc);
        logic [AW:0] sum;
        sum = {1'b0, ptr} + {1'b0, inc};
        if (sum >= DEPTH_X) begin
            sum = sum - DEPTH_X;
        end else begin
            sum = sum;
        end
        return sum[AW-1:0];
    endfunction

    // A window of zero size or larger than the buffer cannot be served.
    function automatic logic cfg_bad(input logic [4:0] ic, input logic [4:0] fw);
        logic [9:0] w;
        w = {5'd0, ic} * {5'd0, fw};
        return (w == 10'd0) || (w > DEPTH_W);
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r,   wr_ptr_n;
    logic [AW-1:0]     base_ptr_r, base_ptr_n;
    logic [AW-1:0]     rd_off_r,   rd_off_n;
    logic [AW-1:0]     occ_r,      occ_n;
    logic [4:0]        ic_r,       ic_n;
    logic [4:0]        fw_r,       fw_n;
    logic [DATA_W-1:0] rd_data_r,  rd_data_n;
    logic              rd_valid_r, rd_valid_n;
    logic              win_done_r, win_done_n;
    logic              err_r,      err_n;

    logic [9:0]    win_sz_s;
    logic          cfg_ok_s;
    logic          win_ready_s;
    logic          full_s;
    logic          wr_acc_s;
    logic          mem_we_s;
    logic          slide_acc_s;
    logic          slide_err_s;
    logic          rd_fire_s;
    logic          rd_last_s;
    logic [AW-1:0] rd_addr_s;
    logic [AW-1:0] ic_a_s;

    // Datapath decode and next-state computation for all control registers.
    always_comb begin
        wr_ptr_n   = wr_ptr_r;
        base_ptr_n = base_ptr_r;
        rd_off_n   = rd_off_r;
        occ_n      = occ_r;
        ic_n       = ic_r;
        fw_n       = fw_r;
        rd_data_n  = rd_data_r;
        rd_valid_n = 1'b0;
        win_done_n = 1'b0;
        err_n      = err_r;

        win_sz_s    = {5'd0, ic_r} * {5'd0, fw_r};
        cfg_ok_s    = (win_sz_s != 10'd0) && (win_sz_s <= DEPTH_W);
        win_ready_s = cfg_ok_s && (10'(occ_r) >= win_sz_s);
        // full is taken before any same-cycle slide, so a write while full
        // is dropped even if a slide frees space in that cycle.
        full_s      = (occ_r == DEPTH_A);
        wr_acc_s    = bus.wr_en && !full_s;
        mem_we_s    = wr_acc_s && !bus.start;
        slide_acc_s = bus.slide && cfg_ok_s && (10'(occ_r) >= 10'(ic_r));
        slide_err_s = bus.slide && cfg_ok_s && (10'(occ_r) < 10'(ic_r));
        // slide wins over rd_en: the read is simply dropped.
        rd_fire_s   = bus.rd_en && win_ready_s && !bus.slide;
        rd_last_s   = (10'(rd_off_r) == (win_sz_s - 10'd1));
        rd_addr_s   = ptr_add(base_ptr_r, rd_off_r);
        // A slide is only accepted when ic <= occ <= DEPTH, so this fits.
        ic_a_s      = AW'(ic_r);

        if (bus.start) begin
            wr_ptr_n   = {AW{1'b0}};
            base_ptr_n = {AW{1'b0}};
            rd_off_n   = {AW{1'b0}};
            occ_n      = {AW{1'b0}};
            ic_n       = bus.cfg_ic;
            fw_n       = bus.cfg_fw;
            err_n      = cfg_bad(bus.cfg_ic, bus.cfg_fw);
        end else begin
            if (wr_acc_s) begin
                wr_ptr_n = ptr_add(wr_ptr_r, {{(AW-1){1'b0}}, 1'b1});
            end else begin
                wr_ptr_n = wr_ptr_r;
            end

            if (slide_acc_s) begin
                base_ptr_n = ptr_add(base_ptr_r, ic_a_s);
            end else begin
                base_ptr_n = base_ptr_r;
            end

            occ_n = occ_r + {{(AW-1){1'b0}}, wr_acc_s}
                          - (slide_acc_s ? ic_a_s : {AW{1'b0}});

            if (slide_acc_s) begin
                rd_off_n = {AW{1'b0}};
            end else if (rd_fire_s) begin
                rd_off_n = rd_last_s ? {AW{1'b0}}
                                     : rd_off_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_off_n = rd_off_r;
            end

            if (rd_fire_s) begin
                rd_data_n = mem_r[rd_addr_s];
            end else begin
                rd_data_n = rd_data_r;
            end
            rd_valid_n = rd_fire_s;
            win_done_n = rd_fire_s && rd_last_s;

            err_n = err_r | (bus.wr_en && full_s) | slide_err_s | !cfg_ok_s;
        end
    end

    // Control and output registers; reset aborts any operation at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            base_ptr_r <= {AW{1'b0}};
            rd_off_r   <= {AW{1'b0}};
            occ_r      <= {AW{1'b0}};
            ic_r       <= 5'd0;
            fw_r       <= 5'd0;
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
            win_done_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_n;
            base_ptr_r <= base_ptr_n;
            rd_off_r   <= rd_off_n;
            occ_r      <= occ_n;
            ic_r       <= ic_n;
            fw_r       <= fw_n;
            rd_data_r  <= rd_data_n;
            rd_valid_r <= rd_valid_n;
            win_done_r <= win_done_n;
            err_r      <= err_n;
        end
    end

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign bus.rd_data   = rd_data_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.win_done  = win_done_r;
    assign bus.win_ready = win_ready_s;
    assign bus.full      = full_s;
    assign bus.occ       = occ_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_ifmap_spad.sv
// tb_ifmap_spad: scoreboard bench for ifmap_spad. Each issued read that
// should be served pushes {win_done, rd_data} onto a queue; a negedge
// monitor pops and compares whenever rd_valid is seen.
module tb_ifmap_spad;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ifmap_spad_if #(.DATA_W(16), .AW(4)) bus ();

    ifmap_spad #(.DATA_W(16), .DEPTH(12), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [16:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given strobes, then strobes dropped.
    task automatic step(input logic w, input logic [15:0] d, input logic r, input logic s);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        bus.slide   = s;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.slide = 1'b0;
    endtask

    task automatic wr(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [15:0] v, input logic done);
        exp_q.push_back({done, v});
        step(1'b0, 16'd0, 1'b1, 1'b0);
    endtask

    task automatic do_start(input logic [4:0] ic, input logic [4:0] fw);
        bus.cfg_ic = ic;
        bus.cfg_fw = fw;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Read-response monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 32'(bus.rd_valid), 32'd0);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("rd_data", 32'(bus.rd_data), 32'(e[15:0]));
                    check("win_done", 32'(bus.win_done), 32'(e[16]));
                end
            end else if (bus.win_done) begin
                check("win_done_alone", 32'(bus.win_done), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.cfg_ic = 5'd0; bus.cfg_fw = 5'd0;
        bus.wr_en = 1'b0; bus.wr_data = 16'd0; bus.rd_en = 1'b0; bus.slide = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_occ", 32'(bus.occ), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_win_ready", 32'(bus.win_ready), 32'd0);
        rst = 1'b0;

        // Fill and read, replay.
        do_start(5'd2, 5'd3);
        check("start_err", 32'(bus.err), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            wr(16'(i));
            if (i == 5) check("win_ready_5", 32'(bus.win_ready), 32'd0);
        end
        check("win_ready_6", 32'(bus.win_ready), 32'd1);
        check("occ_6", 32'(bus.occ), 32'd6);
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 1; i <= 6; i++) rd(16'(i), i == 6);
        end
        check("occ_after_reads", 32'(bus.occ), 32'd6);

        // Slide, refill, then slide mid-window together with rd_en.
        step(1'b0, 16'd0, 1'b0, 1'b1);
        check("occ_slide", 32'(bus.occ), 32'd4);
        wr(16'd7);
        wr(16'd8);
        check("occ_refill", 32'(bus.occ), 32'd6);
        rd(16'd3, 1'b0);
        rd(16'd4, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b1);
        check("slide_rd_drop", 32'(bus.rd_valid), 32'd0);
        check("occ_slide2", 32'(bus.occ), 32'd4);
        wr(16'd9);
        wr(16'd10);
        for (int i = 5; i <= 10; i++) rd(16'(i), i == 10);

        // Slide with occ < ic.
        do_start(5'd2, 5'd3);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        check("slide_underflow_err", 32'(bus.err), 32'd1);
        check("slide_underflow_occ", 32'(bus.occ), 32'd0);

        // Wrap and full.
        do_start(5'd2, 5'd3);
        for (int i = 1; i <= 12; i++) wr(16'(i));
        check("full", 32'(bus.full), 32'd1);
        check("occ_12", 32'(bus.occ), 32'd12);
        check("err_before_ovf", 32'(bus.err), 32'd0);
        wr(16'd13);
        check("ovf_err", 32'(bus.err), 32'd1);
        check("ovf_occ", 32'(bus.occ), 32'd12);
        for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b0, 1'b1);
        check("occ_3slides", 32'(bus.occ), 32'd6);
        check("not_full", 32'(bus.full), 32'd0);
        for (int i = 13; i <= 18; i++) wr(16'(i));
        check("occ_wrapfill", 32'(bus.occ), 32'd12);
        for (int i = 7; i <= 12; i++) rd(16'(i), i == 12);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        for (int i = 9; i <= 14; i++) rd(16'(i), i == 14);
        step(1'b1, 16'd19, 1'b0, 1'b1);
        check("occ_wr_slide", 32'(bus.occ), 32'd9);
        for (int i = 11; i <= 16; i++) rd(16'(i), i == 16);

        // Invalid configuration.
        do_start(5'd4, 5'd4);
        check("cfg_err", 32'(bus.err), 32'd1);
        for (int i = 1; i <= 12; i++) wr(16'(100 + i));
        check("cfg_occ", 32'(bus.occ), 32'd12);
        check("cfg_win_ready", 32'(bus.win_ready), 32'd0);
        step(1'b0, 16'd0, 1'b1, 1'b0);
        check("cfg_rd_valid", 32'(bus.rd_valid), 32'd0);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        check("cfg_slide_ignored", 32'(bus.occ), 32'd12);

        // Reset mid-read.
        do_start(5'd2, 5'd3);
        check("restart_err_clr", 32'(bus.err), 32'd0);
        for (int i = 1; i <= 6; i++) wr(16'(i + 40));
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        check("pre_rst_valid", 32'(bus.rd_valid), 32'd1);
        check("pre_rst_data", 32'(bus.rd_data), 32'd41);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("async_rst_occ", 32'(bus.occ), 32'd0);
        check("async_rst_data", 32'(bus.rd_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
